// File: rtl/mdu_sequencer.sv
// Iterative RV64M multiply/divide/remainder unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with valid/ready on both sides.
module mdu_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op_sel,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int HW = 32;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   counter_q, counter_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            is_mul_q, is_mul_d;
  logic            is_rem_q, is_rem_d;
  logic            mul_hi_q, mul_hi_d;
  logic            is_w_q, is_w_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  // Request decode
  logic            dec_legal, dec_w, dec_mul, dec_div, dec_rem, dec_mulhi, dec_s1, dec_s2;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_val, fast_res;
  logic            neg1, neg2, div_zero, div_ovf, fast;

  always_comb begin
    dec_legal = (op_sel <= 4'd12);
    dec_w     = op_sel inside {4'd4, 4'd7, 4'd8, 4'd11, 4'd12};
    dec_mul   = (op_sel <= 4'd4);
    dec_div   = (op_sel >= 4'd5) && (op_sel <= 4'd8);
    dec_rem   = (op_sel >= 4'd9) && (op_sel <= 4'd12);
    dec_mulhi = op_sel inside {4'd1, 4'd2, 4'd3};
    dec_s1    = op_sel inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11};
    dec_s2    = op_sel inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11};

    ext1 = src1;
    ext2 = src2;
    if (dec_w) begin
      ext1 = {{(XLEN-HW){dec_s1 & src1[HW-1]}}, src1[HW-1:0]};
      ext2 = {{(XLEN-HW){dec_s2 & src2[HW-1]}}, src2[HW-1:0]};
    end
    neg1 = dec_s1 & ext1[XLEN-1];
    neg2 = dec_s2 & ext2[XLEN-1];
    mag1 = neg1 ? -ext1 : ext1;
    mag2 = neg2 ? -ext2 : ext2;

    // W-op extension already folds the 32-bit checks into the XLEN-wide compares
    min_val  = dec_w ? {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (dec_div | dec_rem) & (ext2 == '0);
    div_ovf  = (dec_div | dec_rem) & dec_s1 & (ext1 == min_val) & (ext2 == '1);
    fast     = ~dec_legal | div_zero | div_ovf;

    fast_res = '0;
    if (dec_legal && div_zero) begin
      if (dec_div) fast_res = '1;
      else         fast_res = dec_w ? {{(XLEN-HW){src1[HW-1]}}, src1[HW-1:0]} : src1;
    end else if (dec_legal && div_ovf) begin
      fast_res = dec_div ? ext1 : '0;
    end
  end

  // One iteration of the datapath
  logic [XLEN:0]     mul_sum, div_shift, div_sub;
  logic              div_ge;
  logic [XLEN-1:0]   step_acc, step_lo;
  logic [2*XLEN-1:0] mul_prod, mul_prod_s;
  logic [HW-1:0]     mulw32, w32;
  logic [XLEN-1:0]   div_val, div_val_s, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    // the partial remainder stays below 2*divisor, so XLEN+1 bits hold the sign
    div_sub   = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_sub[XLEN];

    if (is_mul_q) begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      step_acc = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], div_ge};
    end

    mul_prod   = {step_acc, step_lo};
    mul_prod_s = neg_q ? -mul_prod : mul_prod;
    mulw32     = neg_q ? -step_lo[XLEN-1 -: HW] : step_lo[XLEN-1 -: HW];
    div_val    = is_rem_q ? step_acc : step_lo;
    div_val_s  = neg_q ? -div_val : div_val;
    w32        = is_mul_q ? mulw32 : div_val_s[HW-1:0];

    if (is_w_q)        final_res = {{(XLEN-HW){w32[HW-1]}}, w32};
    else if (is_mul_q) final_res = mul_hi_q ? mul_prod_s[2*XLEN-1:XLEN] : mul_prod_s[XLEN-1:0];
    else               final_res = div_val_s;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    is_mul_d  = is_mul_q;
    is_rem_d  = is_rem_q;
    mul_hi_d  = mul_hi_q;
    is_w_d    = is_w_q;
    neg_d     = neg_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          is_mul_d = dec_mul;
          is_rem_d = dec_rem;
          mul_hi_d = dec_mulhi;
          is_w_d   = dec_w;
          neg_d    = dec_rem ? neg1 : (neg1 ^ neg2);
          if (fast) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d   = S_CALC;
            counter_d = dec_w ? CW'(HW) : CW'(XLEN);
            acc_d     = '0;
            if (dec_mul) begin
              lo_d   = mag2;
              opnd_d = mag1;
            end else begin
              // W divides pre-align the dividend so 32 shifts consume all of it
              lo_d   = dec_w ? {mag1[HW-1:0], {(XLEN-HW){1'b0}}} : mag1;
              opnd_d = mag2;
            end
          end
        end
      end
      S_CALC: begin
        acc_d     = step_acc;
        lo_d      = step_lo;
        counter_d = counter_q - CW'(1);
        if (counter_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = final_res;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d   = S_IDLE;
      counter_d = '0;
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      counter_q   <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      is_mul_q    <= 1'b0;
      is_rem_q    <= 1'b0;
      mul_hi_q    <= 1'b0;
      is_w_q      <= 1'b0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      is_mul_q    <= is_mul_d;
      is_rem_q    <= is_rem_d;
      mul_hi_q    <= mul_hi_d;
      is_w_q      <= is_w_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed vector table, DONE-hold/flush/reset sequences,
// then random ops checked against an arithmetic reference model.
module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [3:0]  op_sel;
  logic [63:0] src1, src2, result;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[14];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: plain arithmetic on the RISC-V M-extension rules
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         a32, b32;
    logic signed [127:0] xa, xb, sp;
    logic [127:0]        p;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    xa = {{64{a[63]}}, a};
    xb = {{64{b[63]}}, b};
    case (op)
      4'd0: return a * b;
      4'd1: begin sp = xa * xb; return sp[127:64]; end
      4'd2: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      4'd3: begin p = xa * {64'd0, b}; return p[127:64]; end
      4'd4: return sext32(a32 * b32);
      4'd5: begin
        if (b == 0) return ONES;
        if (a == MIN && b == ONES) return a;
        return sa / sb;
      end
      4'd6: return (b == 0) ? ONES : a / b;
      4'd7: begin
        if (b32 == 0) return ONES;
        if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sext32(a32);
        return sext32(sa32 / sb32);
      end
      4'd8: return (b32 == 0) ? ONES : sext32(a32 / b32);
      4'd9: begin
        if (b == 0) return a;
        if (a == MIN && b == ONES) return 64'd0;
        return sa % sb;
      end
      4'd10: return (b == 0) ? a : a % b;
      4'd11: begin
        if (b32 == 0) return sext32(a32);
        if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
        return sext32(sa32 % sb32);
      end
      4'd12: return (b32 == 0) ? sext32(a32) : sext32(a32 % b32);
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, sgn;
    if (op > 4'd12) return 1;
    w = (op == 4'd4) || (op == 4'd7) || (op == 4'd8) || (op == 4'd11) || (op == 4'd12);
    if (op >= 4'd5) begin
      sgn = (op == 4'd5) || (op == 4'd7) || (op == 4'd9) || (op == 4'd11);
      if (w && b[31:0] == 0) return 1;
      if (!w && b == 0) return 1;
      if (sgn && w && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      if (sgn && !w && a == MIN && b == ONES) return 1;
    end
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return ONES;
      2: return MIN;
      3: return 64'($urandom_range(0, 20));
      4: return {32'd0, 32'h8000_0000};
      5: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; op_sel = op; src1 = a; src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", result, exp);
    chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
    $display("[TB] op=%0d src1=%h src2=%h result=%h expected=%h latency=%0d",
             op, a, b, result, exp, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_handshake", {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [63:0] held;
    logic [3:0]  rop;
    logic [63:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    op_sel = 4'd0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'h8);
    chk("reset_result", result, 64'd0);
    rst_n = 1'b1;

    vecs[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{4'd2,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{4'd1,  ONES, ONES, 64'd0, 65};
    vecs[3]  = '{4'd5,  64'd5, 64'd0, ONES, 1};
    vecs[4]  = '{4'd9,  64'd5, 64'd0, 64'd5, 1};
    vecs[5]  = '{4'd5,  MIN, ONES, MIN, 1};
    vecs[6]  = '{4'd9,  MIN, ONES, 64'd0, 1};
    vecs[7]  = '{4'd7,  64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[8]  = '{4'd11, 64'h0000_0001_FFFF_FFF9, 64'd2, ONES, 33};
    vecs[9]  = '{4'd13, 64'd123, 64'd45, 64'd0, 1};
    vecs[10] = '{4'd6,  64'd100, 64'd7, 64'd14, 65};
    vecs[11] = '{4'd3,  ONES, 64'd2, ONES, 65};
    vecs[12] = '{4'd12, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 33};
    vecs[13] = '{4'd8,  64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Result must hold while the consumer stalls in DONE
    @(negedge clk);
    in_valid = 1'b1; op_sel = 4'd0; src1 = 64'd7; src2 = 64'hFFFF_FFFF_FFFF_FFFD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 200) begin @(posedge clk); #1; cnt++; end
    held = result;
    chk("hold_first_result", held, 64'hFFFF_FFFF_FFFF_FFEB);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_result_stable", result, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("hold_flags", {61'd0, in_ready, out_valid, busy}, 64'h3);
    end
    $display("[TB] done-hold sequence result=%h", result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush at the tenth CALC cycle
    @(negedge clk);
    in_valid = 1'b1; op_sel = 4'd6; src1 = 64'd1000; src2 = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("busy_before_flush", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_to_idle", {61'd0, in_ready, out_valid, busy}, 64'h4);
    cnt = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("no_valid_after_flush", 64'(cnt), 64'd0);
    $display("[TB] flush sequence out_valid_pulses=%0d", cnt);

    // flush together with a request in IDLE drops the request
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op_sel = 4'd5; src1 = 64'd5; src2 = 64'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_drops_request", {61'd0, in_ready, out_valid, busy}, 64'h4);
    $display("[TB] flush+in_valid sequence busy=%0b", busy);

    // Reset in the middle of CALC
    @(negedge clk);
    in_valid = 1'b1; op_sel = 4'd0; src1 = 64'd99; src2 = 64'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_calc_flags", {61'd0, in_ready, out_valid, busy}, 64'h4);
    chk("reset_mid_calc_result", result, 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("no_valid_after_reset", 64'(cnt), 64'd0);
    $display("[TB] reset-mid-calc sequence result=%h", result);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, ref_result(rop, ra, rb), ref_lat(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
